// File: rtl/fir_out_stage.sv
// fir_out_stage: converts FIR datapath results to OUT_W-bit samples
// (right shift, optional round-half-up, unsigned saturation), queues them
// in a DEPTH-entry FIFO and delivers them over a valid/ready handshake.
// A sticky overflow flag records strobes dropped while the FIFO was full.
// Build option: define FIR_OUT_ROUND_EN to add 1<<(SHIFT-1) before the shift.
module fir_out_stage #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 8,
    parameter int SHIFT = 10,
    parameter int DEPTH = 4
) (
    input  logic                       ph1,
    input  logic                       reset,
    input  logic [IN_W-1:0]            yIn,
    input  logic                       yStrobe,
    input  logic                       outReady,
    input  logic                       clearOvf,
    output logic                       outValid,
    output logic [OUT_W-1:0]           outData,
    output logic                       outSat,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef FIR_OUT_ROUND_EN
    localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
`else
    localparam logic [IN_W:0] RND = '0;
`endif

    // Storage holds {sat, data}
    logic [OUT_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count_next;

    logic [IN_W:0]      v;
    logic [IN_W:0]      v_sh;
    logic               conv_sat;
    logic [OUT_W-1:0]   conv_data;

    logic               full;
    logic               push;
    logic               pop;
    logic [OUT_W:0]     head_next;

    // Sample conversion: add rounding constant, shift, saturate on any high bit
    always_comb begin
        v         = {1'b0, yIn} + RND;
        v_sh      = v >> SHIFT;
        conv_sat  = |(v_sh >> OUT_W);
        conv_data = conv_sat ? '1 : v_sh[OUT_W-1:0];
    end

    // Handshake decode and next-state for pointers, count and head entry
    always_comb begin
        full        = (count == FULL_CNT);
        pop         = outValid && outReady;
        push        = yStrobe && (!full || pop);
        rd_ptr_next = pop ? rd_ptr + PTR_ONE : rd_ptr;

        count_next = count;
        if (push && !pop)
            count_next = count + CNT_ONE;
        else if (pop && !push)
            count_next = count - CNT_ONE;

        // Head is registered, so when the next read slot is the one being
        // written this edge, bypass the incoming sample instead of reading mem.
        if (count_next == '0)
            head_next = '0;
        else if (push && (rd_ptr_next == wr_ptr))
            head_next = {conv_sat, conv_data};
        else
            head_next = mem[rd_ptr_next];
    end

    // Control state and registered outputs
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outSat   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            outValid <= (count_next != '0);
            outSat   <= head_next[OUT_W];
            outData  <= head_next[OUT_W-1:0];
            if (yStrobe && full && !pop)
                overflow <= 1'b1;
            else if (clearOvf)
                overflow <= 1'b0;
        end
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge ph1) begin
        if (push)
            mem[wr_ptr] <= {conv_sat, conv_data};
    end

endmodule
